// File: rtl/uart_clk_div_gen.sv
// rtl/uart_clk_div_gen.sv - UART sampling-clock divider with tick and registered divided clock
// Optional macro CLKDIV_ERR_STATUS_EN enables the sticky o_cfg_err flag.
module uart_clk_div_gen #(
  parameter int PRESCALE_WIDTH  = 6,
  parameter int DIV_RATIO_WIDTH = 8,
  parameter int MAX_PRESCALE    = 32,
  parameter int PRESCALE_MIN    = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_enable,
  input  logic                       i_mode,
  input  logic [PRESCALE_WIDTH-1:0]  i_prescale,
  input  logic [DIV_RATIO_WIDTH-1:0] i_div_ratio,
  input  logic                       i_err_clr,
  output logic                       o_div_tick,
  output logic                       o_div_clk,
  output logic [DIV_RATIO_WIDTH-1:0] o_ratio_active,
  output logic                       o_cfg_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [DIV_RATIO_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_RATIO_WIDTH-1:0] ratio_q, ratio_d;
  logic [DIV_RATIO_WIDTH-1:0] tbl_ratio;
  logic [DIV_RATIO_WIDTH-1:0] r_new;
  logic [DIV_RATIO_WIDTH:0]   half_d;
  logic                       tbl_legal;
  logic                       tick;
  logic                       div_clk_q, div_clk_d;
  logic                       err_q, err_d;

  // Legal prescales are single powers of two, so the ratio is a shift of MAX_PRESCALE.
  always_comb begin
    tbl_legal = 1'b0;
    tbl_ratio = '0;
    for (int i = 0; i < PRESCALE_WIDTH; i++) begin
      if ((1 << i) >= PRESCALE_MIN && (1 << i) <= MAX_PRESCALE &&
          i_prescale == PRESCALE_WIDTH'(1 << i)) begin
        tbl_legal = 1'b1;
        tbl_ratio = DIV_RATIO_WIDTH'(MAX_PRESCALE >> i);
      end
    end
  end

  always_comb begin
    r_new = DIV_RATIO_WIDTH'(1);
    if (i_mode) begin
      if (i_div_ratio != '0) r_new = i_div_ratio;
    end else if (tbl_legal) begin
      r_new = tbl_ratio;
    end
  end

  assign tick = (state_q == ST_RUN) && (cnt_q == ratio_q - 1'b1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ratio_d = ratio_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (i_enable) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        ratio_d = r_new;
        cnt_d   = '0;
        state_d = i_enable ? ST_RUN : ST_IDLE;
      end
      ST_RUN: begin
        if (!i_enable) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (tick) begin
          cnt_d   = '0;
          ratio_d = r_new;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Divided clock is registered from next-state so it lines up with cnt in the same cycle.
  assign half_d    = ({1'b0, ratio_d} + 1'b1) >> 1;
  assign div_clk_d = (state_d == ST_RUN) && ({1'b0, cnt_d} < half_d);

`ifdef CLKDIV_ERR_STATUS_EN
  logic cfg_illegal;
  logic capture;
  assign cfg_illegal = i_mode ? (i_div_ratio == '0) : !tbl_legal;
  assign capture     = (state_q == ST_LOAD) || ((state_q == ST_RUN) && i_enable && tick);
  assign err_d       = (capture && cfg_illegal) || (err_q && !i_err_clr);
`else
  assign err_d = err_q && !i_err_clr;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ratio_q   <= DIV_RATIO_WIDTH'(1);
      div_clk_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ratio_q   <= ratio_d;
      div_clk_q <= div_clk_d;
      err_q     <= err_d;
    end
  end

  assign o_div_tick     = tick;
  assign o_div_clk      = div_clk_q;
  assign o_ratio_active = ratio_q;
  assign o_cfg_err      = err_q;

endmodule

// File: tb/tb_uart_clk_div_gen.sv
// tb/tb_uart_clk_div_gen.sv - self-checking bench for uart_clk_div_gen
// Honours CLKDIV_ERR_STATUS_EN when compiled with the same define as the RTL.
module tb_uart_clk_div_gen;

  localparam int PW   = 6;
  localparam int DW   = 8;
  localparam int MAXP = 32;
  localparam int MINP = 4;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_enable;
  logic          i_mode;
  logic [PW-1:0] i_prescale;
  logic [DW-1:0] i_div_ratio;
  logic          i_err_clr;
  logic          o_div_tick;
  logic          o_div_clk;
  logic [DW-1:0] o_ratio_active;
  logic          o_cfg_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: run stage, active ratio, cycle at which the current period began.
  int m_st;
  int m_r;
  int m_start;
  bit m_err;
  bit err_en;

  uart_clk_div_gen #(
    .PRESCALE_WIDTH (PW),
    .DIV_RATIO_WIDTH(DW),
    .MAX_PRESCALE   (MAXP),
    .PRESCALE_MIN   (MINP)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_enable      (i_enable),
    .i_mode        (i_mode),
    .i_prescale    (i_prescale),
    .i_div_ratio   (i_div_ratio),
    .i_err_clr     (i_err_clr),
    .o_div_tick    (o_div_tick),
    .o_div_clk     (o_div_clk),
    .o_ratio_active(o_ratio_active),
    .o_cfg_err     (o_cfg_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  function automatic void resolve(input bit md, input int ps, input int dr,
                                  output int r, output bit ill);
    if (md) begin
      ill = (dr == 0);
      r   = ill ? 1 : dr;
    end else begin
      ill = !(ps >= MINP && ps <= MAXP && $countones(ps) == 1);
      r   = ill ? 1 : MAXP / ps;
    end
  endfunction

  task automatic step(input bit rst, input bit en, input bit md,
                      input int ps, input int dr, input bit clr);
    int r;
    int pos;
    bit ill;
    bit cap;
    bit run;
    i_rst       = rst;
    i_enable    = en;
    i_mode      = md;
    i_prescale  = ps[PW-1:0];
    i_div_ratio = dr[DW-1:0];
    i_err_clr   = clr;
    resolve(md, int'(i_prescale), int'(i_div_ratio), r, ill);
    cap = 1'b0;
    if (rst) begin
      m_st  = 0;
      m_r   = 1;
      m_err = 1'b0;
    end else begin
      case (m_st)
        0: if (en) m_st = 1;
        1: begin
          m_r = r;
          cap = 1'b1;
          if (en) begin
            m_st    = 2;
            m_start = cyc + 1;
          end else begin
            m_st = 0;
          end
        end
        default: begin
          pos = cyc - m_start;
          if (!en) begin
            m_st = 0;
          end else if (pos == m_r - 1) begin
            m_r     = r;
            cap     = 1'b1;
            m_start = cyc + 1;
          end
        end
      endcase
      if (err_en && cap && ill) m_err = 1'b1;
      else if (clr)             m_err = 1'b0;
    end
    @(negedge i_clk);
    cyc++;
    run = (m_st == 2);
    pos = cyc - m_start;
    check("tick",    int'(o_div_tick),     (run && pos == m_r - 1) ? 1 : 0);
    check("div_clk", int'(o_div_clk),      (run && pos < (m_r + 1) / 2) ? 1 : 0);
    check("ratio",   int'(o_ratio_active), m_r);
    check("cfg_err", int'(o_cfg_err),      m_err ? 1 : 0);
  endtask

  task automatic go_idle();
    repeat (3) step(1'b0, 1'b0, 1'b0, 8, 0, 1'b0);
  endtask

  initial begin
    int t0;
    int rel;
    int hold;
    int ps;
    int dr;
    bit md;
    int ps_tab[10] = '{4, 8, 16, 32, 12, 0, 1, 2, 48, 63};

    err_en = 1'b0;
`ifdef CLKDIV_ERR_STATUS_EN
    err_en = 1'b1;
`endif
    i_rst = 1'b1; i_enable = 1'b0; i_mode = 1'b0;
    i_prescale = '0; i_div_ratio = '0; i_err_clr = 1'b0;
    m_st = 0; m_r = 1; m_start = 0; m_err = 1'b0;
    hold = 0; ps = 8; dr = 1; md = 1'b0;
    @(negedge i_clk);

    // Reset state
    step(1'b1, 1'b0, 1'b0, 8, 0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8, 0, 1'b0);
    check("rst_tick",  int'(o_div_tick), 0);
    check("rst_clk",   int'(o_div_clk), 0);
    check("rst_ratio", int'(o_ratio_active), 1);
    check("rst_err",   int'(o_cfg_err), 0);

    // Table mode prescale 8 -> R=4, ticks at 5, 9, 13
    t0 = cyc;
    repeat (15) begin
      step(1'b0, 1'b1, 1'b0, 8, 0, 1'b0);
      rel = cyc - t0;
      check("t1_tick", int'(o_div_tick), (rel == 5 || rel == 9 || rel == 13) ? 1 : 0);
      if (rel >= 2) begin
        check("t1_clk",   int'(o_div_clk), ((rel - 2) % 4 < 2) ? 1 : 0);
        check("t1_ratio", int'(o_ratio_active), 4);
      end
    end

    // Prescale 32 -> R=1
    go_idle();
    t0 = cyc;
    repeat (8) begin
      step(1'b0, 1'b1, 1'b0, 32, 0, 1'b0);
      rel = cyc - t0;
      check("t2_tick", int'(o_div_tick), (rel >= 2) ? 1 : 0);
      check("t2_clk",  int'(o_div_clk),  (rel >= 2) ? 1 : 0);
    end

    // Direct ratio 5
    go_idle();
    t0 = cyc;
    repeat (20) begin
      step(1'b0, 1'b1, 1'b1, 8, 5, 1'b0);
      rel = cyc - t0;
      if (rel >= 2) begin
        check("t3_tick",  int'(o_div_tick), ((rel - 2) % 5 == 4) ? 1 : 0);
        check("t3_clk",   int'(o_div_clk),  ((rel - 2) % 5 < 3) ? 1 : 0);
        check("t3_ratio", int'(o_ratio_active), 5);
      end
    end

    // Ratio change 2 -> 4 applied at the wrap
    go_idle();
    t0 = cyc;
    repeat (12) begin
      step(1'b0, 1'b1, 1'b0, (cyc - t0 >= 4) ? 8 : 16, 0, 1'b0);
      rel = cyc - t0;
      if (rel == 5) begin
        check("t4_tick_old",  int'(o_div_tick), 1);
        check("t4_ratio_old", int'(o_ratio_active), 2);
      end
      if (rel >= 6) begin
        check("t4_ratio_new", int'(o_ratio_active), 4);
        check("t4_tick_new",  int'(o_div_tick), (rel == 9) ? 1 : 0);
      end
    end

    // Illegal prescale 12 -> R=1, sticky error when enabled
    go_idle();
    t0 = cyc;
    repeat (6) begin
      step(1'b0, 1'b1, 1'b0, 12, 0, 1'b0);
      rel = cyc - t0;
      if (rel >= 2) begin
        check("t5_ratio", int'(o_ratio_active), 1);
        check("t5_err",   int'(o_cfg_err), err_en ? 1 : 0);
      end
    end
    repeat (3) step(1'b0, 1'b1, 1'b0, 8, 0, 1'b0);
    check("t5_err_hold", int'(o_cfg_err), err_en ? 1 : 0);
    step(1'b0, 1'b1, 1'b0, 8, 0, 1'b1);
    check("t5_err_clr", int'(o_cfg_err), 0);

    // Mid-period abort at cnt=2 of R=4, then restart
    go_idle();
    t0 = cyc;
    while (cyc - t0 < 4) step(1'b0, 1'b1, 1'b0, 8, 0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8, 0, 1'b0);
    check("t6_abort_tick", int'(o_div_tick), 0);
    check("t6_abort_clk",  int'(o_div_clk), 0);
    step(1'b0, 1'b0, 1'b0, 8, 0, 1'b0);
    t0 = cyc;
    repeat (7) begin
      step(1'b0, 1'b1, 1'b0, 8, 0, 1'b0);
      rel = cyc - t0;
      check("t6_restart_tick", int'(o_div_tick), (rel == 5) ? 1 : 0);
    end
    // Same abort by reset pulse
    go_idle();
    t0 = cyc;
    while (cyc - t0 < 4) step(1'b0, 1'b1, 1'b0, 8, 0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8, 0, 1'b0);
    check("t6_rst_tick",  int'(o_div_tick), 0);
    check("t6_rst_clk",   int'(o_div_clk), 0);
    check("t6_rst_ratio", int'(o_ratio_active), 1);
    t0 = cyc;
    repeat (7) begin
      step(1'b0, 1'b1, 1'b0, 8, 0, 1'b0);
      rel = cyc - t0;
      check("t6_rst_restart", int'(o_div_tick), (rel == 5) ? 1 : 0);
    end

    // Randomised configuration, enable, clear and reset traffic
    for (int k = 0; k < 4000; k++) begin
      if (hold == 0) begin
        md   = ($urandom_range(0, 1) == 1);
        ps   = ps_tab[$urandom_range(0, 9)];
        dr   = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 255))
                                            : int'($urandom_range(0, 9));
        hold = int'($urandom_range(1, 40));
      end
      hold--;
      step($urandom_range(0, 299) == 0, $urandom_range(0, 19) != 0, md, ps, dr,
           $urandom_range(0, 9) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_clk_div_gen.md
Name: uart_clk_div_gen

Overview:
Parametrised UART sampling-clock generator. Resolves a division ratio from either a prescale code (table mode) or a direct ratio (direct mode). Divides the system clock by that ratio and produces a one-cycle enable tick plus a registered divided clock. It sits between the configuration register file and the UART RX/TX cores. Ratio updates apply only on period boundaries, so no truncated periods are emitted.

Parameters:
PRESCALE_WIDTH, 6, width of i_prescale
DIV_RATIO_WIDTH, 8, width of i_div_ratio, the active-ratio register and o_ratio_active
MAX_PRESCALE, 32, oversampling rate that maps to ratio 1; power of two
PRESCALE_MIN, 4, smallest legal prescale; power of two; MAX_PRESCALE/PRESCALE_MIN must fit in DIV_RATIO_WIDTH

Ports:
i_clk  input  1  system clock, rising edge
i_rst  input  1  synchronous active-high reset
i_enable  input  1  run divider
i_mode  input  1  0 = table mode, 1 = direct mode
i_prescale  input  PRESCALE_WIDTH  oversampling prescale (table mode)
i_div_ratio  input  DIV_RATIO_WIDTH  division ratio (direct mode)
i_err_clr  input  1  clears o_cfg_err
o_div_tick  output  1  one-cycle pulse, once per divided period
o_div_clk  output  1  divided clock, registered
o_ratio_active  output  DIV_RATIO_WIDTH  ratio currently in use
o_cfg_err  output  1  sticky illegal-configuration flag

Behaviour:
- One clock (i_clk). Reset i_rst is synchronous and active-high and has priority over all other inputs.
- Reset values: o_div_tick=0, o_div_clk=0, o_ratio_active=1, o_cfg_err=0, state IDLE, cnt=0.
- Resolved ratio R_new is combinational:
  - Table mode: legal prescale is a power of two in [PRESCALE_MIN, MAX_PRESCALE]; R_new = MAX_PRESCALE/i_prescale. Any other prescale gives R_new=1 and flags illegal.
  - Direct mode: R_new = i_div_ratio. A value of 0 gives R_new=1 and flags illegal.
- States:
  - IDLE: cnt=0, all pulse/clock outputs 0. Go to LOAD when i_enable=1.
  - LOAD: one cycle. Capture R_new into o_ratio_active and set cnt=0. Go to RUN. If i_enable=0, go to IDLE instead.
  - RUN: cnt increments each cycle and wraps from R-1 to 0. If i_enable=0, go to IDLE at the next edge (mid-period abort allowed); outputs are 0 from the following cycle.
- o_div_tick is decoded from registers only: it is 1 when state=RUN and cnt=R-1. When R=1 it is 1 every RUN cycle.
- o_div_clk is a flop whose value in a RUN cycle equals (cnt < ceil(R/2)). It is high for ceil(R/2) cycles and low for floor(R/2). When R=1 it is constantly 1. It is 0 outside RUN.
- Latency: with i_enable sampled high at cycle N in IDLE, the first RUN cycle is N+2 and the first tick is at N+1+R.
- Ratio change: R_new is sampled only at the edge ending a tick cycle (wrap). o_ratio_active updates there and the next period uses the new R. The inputs may change freely mid-period without effect.
- Mode change is treated as a ratio change (applied at wrap).
- o_ratio_active is stable between wraps.

Optional Feature:
CLKDIV_ERR_STATUS_EN.
- Defined: o_cfg_err is set when an illegal configuration is captured (at LOAD or at wrap). It stays set until i_err_clr=1 or i_rst. If set and clear occur in the same cycle, set wins.
- Not defined: o_cfg_err is tied to 0 and i_err_clr is ignored. Ports remain present. Illegal configurations still fall back to R=1.

Test Plan:
1. Reset, table mode, prescale=8, enable rises at cycle 0 -> o_ratio_active=4; ticks at cycles 5, 9, 13; o_div_clk high 2 / low 2 starting at cycle 2.
2. Table mode, prescale=32 -> R=1; o_div_tick=1 every cycle from cycle 2; o_div_clk constant 1.
3. Direct mode, i_div_ratio=5 -> tick every 5 cycles; o_div_clk high 3 / low 2; o_ratio_active=5.
4. Running at prescale=16 (R=2), prescale switched to 8 at cnt=0 -> the current 2-cycle period completes, o_ratio_active becomes 4 after that tick, and the next tick comes 4 cycles later.
5. Table mode, prescale=12 with CLKDIV_ERR_STATUS_EN -> R=1 and o_cfg_err=1 until an i_err_clr pulse; without the macro -> R=1 and o_cfg_err stays 0.
6. i_enable deasserted (or i_rst pulsed) at cnt=2 of R=4 -> o_div_tick/o_div_clk are 0 from the following cycle and state is IDLE; re-enable -> LOAD, then first tick R cycles after RUN entry.
